// File: rtl/reg_file16.sv
// reg_file16: general-purpose register file with a per-register busy scoreboard.
//
// Sits between writeback and the ALU operand mux. Register 0 is hardwired to
// zero and can never be locked.
//
// Ports:
//   CLK           rising-edge clock
//   RES           synchronous active-high reset, overrides we and lock_en
//   raddr_a/b     read addresses
//   rdata_a/b     combinational read data, write-through bypass from wdata
//   busy_a/b      combinational scoreboard state of raddr_a/b; a register
//                 written this cycle reads not-busy
//   we/waddr/wdata  writeback port; a write also releases the busy bit
//   lock_en/lock_addr  issue-side lock, marks lock_addr busy from next cycle
//   lock_conflict combinational; lock requested on a register that stays busy
//   busy_vec      registered scoreboard bits, bit i = register i
module reg_file16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic             lock_conflict,
  output logic [NREGS-1:0] busy_vec
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(0);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Qualified write and lock requests; address 0 never takes effect.
  logic wr_act;
  logic lk_act;
  assign wr_act = we && (waddr != ZERO_ADDR);
  assign lk_act = lock_en && (lock_addr != ZERO_ADDR);

  // Next-state for data and scoreboard.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_act) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    // Applied after the release so a same-cycle lock wins: new producer owns it.
    if (lk_act) begin
      busy_d[lock_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports with write-through bypass.
  logic hit_a;
  logic hit_b;
  assign hit_a = wr_act && (waddr == raddr_a);
  assign hit_b = wr_act && (waddr == raddr_b);

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != ZERO_ADDR) begin
      rdata_a = hit_a ? wdata : regs_q[raddr_a];
    end
    if (raddr_b != ZERO_ADDR) begin
      rdata_b = hit_b ? wdata : regs_q[raddr_b];
    end
  end

  // Busy read: a pending write releases the register this cycle; locks are
  // not forwarded.
  assign busy_a = busy_q[raddr_a] & ~hit_a;
  assign busy_b = busy_q[raddr_b] & ~hit_b;

  assign lock_conflict = lk_act && busy_q[lock_addr]
                         && !(we && (waddr == lock_addr));

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file16.sv
// tb_reg_file16: scoreboard bench for reg_file16. A driver issues directed
// and random cycles, pushing the expected outputs from an array-based
// reference model; a monitor pops and compares each cycle.
module tb_reg_file16;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;

  logic          CLK = 1'b0;
  logic          RES = 1'b0;
  logic [AW-1:0] raddr_a = '0, raddr_b = '0, waddr = '0, lock_addr = '0;
  logic [W-1:0]  rdata_a, rdata_b, wdata = '0;
  logic          busy_a, busy_b, we = 1'b0, lock_en = 1'b0, lock_conflict;
  logic [N-1:0]  busy_vec;

  reg_file16 #(.WIDTH(W), .NREGS(N), .AW(AW)) dut (
    .CLK(CLK), .RES(RES),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .we(we), .waddr(waddr), .wdata(wdata),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .lock_conflict(lock_conflict), .busy_vec(busy_vec)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          step;
    logic [W-1:0] rd_a;
    logic [W-1:0] rd_b;
    logic         bz_a;
    logic         bz_b;
    logic         conf;
    logic [N-1:0] bvec;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;

  // Reference model: plain arrays of register contents and busy flags.
  int unsigned mdl_val [N];
  bit          mdl_busy[N];

  function automatic int unsigned model_read(int a, bit w, int wa, int unsigned wd);
    if (a == 0) return 0;
    if (w && wa == a) return wd;
    return mdl_val[a];
  endfunction

  // One cycle: drive, record expectation, advance the model.
  task automatic cycle(input bit res, input bit w, input int wa, input int unsigned wd,
                       input bit le, input int la, input int ra, input int rb,
                       input bit chk);
    exp_t e;
    @(negedge CLK);
    RES = res; we = w; waddr = AW'(wa); wdata = W'(wd);
    lock_en = le; lock_addr = AW'(la); raddr_a = AW'(ra); raddr_b = AW'(rb);
    step_no++;
    if (chk) begin
      e.step = step_no;
      e.rd_a = W'(model_read(ra, w, wa, wd));
      e.rd_b = W'(model_read(rb, w, wa, wd));
      e.bz_a = (ra != 0) && mdl_busy[ra] && !(w && wa == ra);
      e.bz_b = (rb != 0) && mdl_busy[rb] && !(w && wa == rb);
      e.conf = le && (la != 0) && mdl_busy[la] && !(w && wa == la);
      for (int i = 0; i < int'(N); i++) e.bvec[i] = mdl_busy[i];
      exp_q.push_back(e);
    end
    if (res) begin
      for (int i = 0; i < int'(N); i++) begin
        mdl_val[i] = 0;
        mdl_busy[i] = 1'b0;
      end
    end else begin
      if (w && wa != 0) begin
        mdl_val[wa] = wd;
        mdl_busy[wa] = 1'b0;
      end
      if (le && la != 0) mdl_busy[la] = 1'b1;
    end
  endtask

  task automatic idle_read(input int ra, input int rb);
    cycle(0, 0, 0, 0, 0, 0, ra, rb, 1);
  endtask

  task automatic check(input string nm, input int st, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, st, got, want);
    end
  endtask

  // Monitor: outputs are combinational, sampled mid low-phase after driving.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdata_a", e.step, rdata_a, e.rd_a);
        check("rdata_b", e.step, rdata_b, e.rd_b);
        check("busy_a", e.step, W'(busy_a), W'(e.bz_a));
        check("busy_b", e.step, W'(busy_b), W'(e.bz_b));
        check("lock_conflict", e.step, W'(lock_conflict), W'(e.conf));
        check("busy_vec", e.step, W'(busy_vec), W'(e.bvec));
      end
    end
  end

  function automatic int pick_addr();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, N - 1));
  endfunction

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      mdl_val[i] = 0;
      mdl_busy[i] = 1'b0;
    end
    // Initial reset: state before it is unknown, so nothing is checked.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Every address reads zero after reset.
    for (int i = 0; i < int'(N); i++) idle_read(i, N - 1 - i);

    // Write with same-cycle bypass, then normal read; write to r0 ignored.
    cycle(0, 1, 5, 16'hBEEF, 0, 0, 5, 0, 1);
    idle_read(5, 5);
    cycle(0, 1, 0, 16'h1234, 0, 0, 0, 0, 1);
    idle_read(0, 5);

    // Lock r3, then release it with a write.
    cycle(0, 0, 0, 0, 1, 3, 3, 0, 1);
    idle_read(3, 3);
    cycle(0, 1, 3, 16'h00AA, 0, 0, 3, 3, 1);
    idle_read(3, 0);

    // Simultaneous lock and write on r7: busy stays, data updates.
    cycle(0, 1, 7, 16'h5555, 1, 7, 7, 0, 1);
    idle_read(7, 7);

    // Double lock on r9 conflicts; with a concurrent write it does not.
    cycle(0, 0, 0, 0, 1, 9, 9, 0, 1);
    cycle(0, 0, 0, 0, 1, 9, 9, 0, 1);
    cycle(0, 1, 9, 16'h0909, 1, 9, 9, 9, 1);
    idle_read(9, 0);
    // Lock on r0 is ignored.
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 1);
    idle_read(0, 0);

    // Load all registers, lock two, then reset with a concurrent write.
    for (int i = 1; i < int'(N); i++) cycle(0, 1, i, 32'h1100 + i * 7, 0, 0, i, 0, 1);
    cycle(0, 0, 0, 0, 1, 2, 2, 4, 1);
    cycle(0, 0, 0, 0, 1, 4, 2, 4, 1);
    cycle(1, 1, 6, 16'hCAFE, 1, 8, 6, 2, 1);
    for (int i = 0; i < int'(N); i++) idle_read(i, (i + 6) % N);

    // Randomized traffic focused on a few colliding addresses.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 59) == 0), bit'($urandom_range(0, 1)), pick_addr(),
            $urandom_range(0, 16'hFFFF), bit'($urandom_range(0, 1)), pick_addr(),
            pick_addr(), pick_addr(), 1);
    end

    // Drain the scoreboard, bounded.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge CLK);
    #4;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file16.md
Name: reg_file16

Overview:
- General-purpose register file built from an array of 16-bit registers with the same storage semantics as the codebase's register: synchronous clear on reset, and capture on the rising clock edge.
- Sits directly downstream of writeback and upstream of the ALU operand mux.
- Provides two combinational read ports with write-through bypass and one write port.
- Keeps a per-register busy scoreboard: issue logic locks a destination register, and writeback unlocks it.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 16, number of registers.
- AW, 4, address width; must satisfy 2^AW = NREGS.

Ports:
- CLK  input  1  clock, rising edge.
- RES  input  1  synchronous reset, active-high.
- raddr_a  input  AW  read port A address.
- raddr_b  input  AW  read port B address.
- rdata_a  output  WIDTH  read port A data, combinational.
- rdata_b  output  WIDTH  read port B data, combinational.
- busy_a  output  1  scoreboard state of raddr_a, combinational.
- busy_b  output  1  scoreboard state of raddr_b, combinational.
- we  input  1  write enable (writeback).
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- lock_en  input  1  mark lock_addr busy (issue).
- lock_addr  input  AW  register to lock.
- lock_conflict  output  1  combinational; lock requested on a register that stays busy.
- busy_vec  output  NREGS  registered scoreboard bits, bit i = register i.

Behaviour:
- Reset (RES high at a rising edge):
  - All registers and all busy bits go to 0 on that edge; RES overrides we and lock_en.
  - After reset, rdata_* = 0 for every address, busy_* = 0, busy_vec = 0.
- Register 0 is hardwired:
  - Reads always return 0.
  - Writes to it are ignored.
  - Locks on it are ignored and never set busy_vec[0].
  - busy_* and lock_conflict for address 0 are always 0.
- Write timing:
  - When we=1 and waddr!=0, reg[waddr] <= wdata at the rising edge.
  - Visible through normal read one cycle later; zero-latency through bypass.
- Read bypass:
  - If we=1, waddr!=0 and waddr==raddr_x, then rdata_x = wdata in the same cycle.
  - Otherwise rdata_x = reg[raddr_x].
  - Both ports bypass independently and may read the same address.
- Scoreboard next-state for each register i != 0:
  - Set if lock_en && lock_addr==i.
  - Else clear if we && waddr==i.
  - Else hold.
  - A simultaneous lock and write to the same register leaves it busy, with the new data stored: the new producer wins.
- busy_x read with bypass:
  - busy_x = busy_vec[raddr_x] & ~(we && waddr==raddr_x).
  - A register being written this cycle reads not-busy.
  - A lock issued this cycle is not visible until the next cycle; no lock-to-read bypass.
- lock_conflict:
  - Asserts when lock_en=1, lock_addr!=0, busy_vec[lock_addr]=1, and not (we && waddr==lock_addr).
  - The lock is still applied: the bit stays 1.
  - The signal is informational; the block does not stall.
- A write to a non-busy register is legal and updates data; busy stays 0.
- Address range: all 2^AW addresses are valid, with no out-of-range case.
- Reset asserted mid-sequence (pending locks, concurrent write) clears everything; no write or lock on the reset edge takes effect.

Test Plan:
- Reset, then read all 16 addresses on both ports -> every rdata = 0x0000, busy_vec = 0x0000.
- Write 0xBEEF to r5 with raddr_a=5 in the same cycle -> rdata_a = 0xBEEF (bypass). Next cycle with we=0 -> rdata_a = 0xBEEF. Write 0x1234 to r0 -> rdata for address 0 stays 0x0000.
- lock r3 -> next cycle busy_vec = 0x0008 and busy_a=1 at raddr_a=3. Write 0x00AA to r3 -> busy_a=0 and rdata_a=0x00AA in that cycle; busy_vec = 0x0000 next cycle.
- Same cycle lock r7 and write 0x5555 to r7 -> next cycle busy_vec[7]=1 and rdata at address 7 = 0x5555.
- Lock r9 twice on consecutive cycles without a write -> lock_conflict=1 on the second lock only; busy_vec[9] stays 1. Repeat with a concurrent write to r9 -> lock_conflict=0.
- Load r1..r15 with distinct values and lock r2 and r4, then pulse RES together with we=1 to r6 -> all registers 0, busy_vec = 0x0000, r6 reads 0x0000.
